// File: rtl/ab_net_pipe.sv
// Two-stage valid/ready pipeline evaluating LANES parallel A/B/NET/feedback bit functions,
// with a saturating count of the 1 bits in every consumed output beat.
module ab_net_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_mode_i,
    input  logic [LANES-1:0] in_x_i,
    input  logic [LANES-1:0] in_y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [LANES-1:0] out_z_o,
    output logic [CNT_W-1:0] ones_cnt_o,
    output logic             ovf_o
);

    // Sum is widened so a full popcount can never wrap before the saturation compare.
    localparam int SUM_W = CNT_W + $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_NET = 2'b00,
        MODE_A   = 2'b01,
        MODE_B   = 2'b10,
        MODE_FB  = 2'b11
    } mode_e;

    logic             s1Valid_q, s1Valid_d;
    mode_e            s1Mode_q, s1Mode_d;
    logic [LANES-1:0] s1X_q, s1X_d;
    logic [LANES-1:0] s1Y_q, s1Y_d;
    logic             s2Valid_q, s2Valid_d;
    logic [LANES-1:0] outZ_q, outZ_d;
    logic [LANES-1:0] fb_q, fb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             s2Adv, s1Adv, inAccept, outConsume;
    logic [LANES-1:0] laneZ;
    logic [SUM_W-1:0] popCnt, sum;

    assign s2Adv      = ~s2Valid_q | out_ready_i;
    assign s1Adv      = s1Valid_q & s2Adv;
    assign in_ready_o = ~s1Valid_q | s2Adv;
    assign inAccept   = in_valid_i & in_ready_o;
    assign outConsume = s2Valid_q & out_ready_i;

    always_comb begin
        laneZ = '0;
        for (int i = 0; i < LANES; i++) begin
            case (s1Mode_q)
                MODE_NET: laneZ[i] = s1X_q[i] | ~s1Y_q[i];
                MODE_A:   laneZ[i] = s1X_q[i] & ~s1Y_q[i];
                MODE_B:   laneZ[i] = ~(s1X_q[i] ^ s1Y_q[i]);
                default:  laneZ[i] = s1X_q[i] | ~(s1Y_q[i] ^ fb_q[i]);
            endcase
        end
    end

    // S1 only loads on accept, so a stalled beat keeps its operands and never touches fb.
    always_comb begin
        s1Mode_d = s1Mode_q;
        s1X_d    = s1X_q;
        s1Y_d    = s1Y_q;
        if (inAccept) begin
            s1Mode_d = mode_e'(in_mode_i);
            s1X_d    = in_x_i;
            s1Y_d    = in_y_i;
        end
        s1Valid_d = inAccept | (s1Valid_q & ~s1Adv);
        s2Valid_d = s1Adv | (s2Valid_q & ~out_ready_i);
        outZ_d    = s1Adv ? laneZ : outZ_q;
        fb_d      = fb_q;
        if (clr_i) begin
            fb_d = '0;
        end else if (s1Adv && (s1Mode_q == MODE_FB)) begin
            fb_d = laneZ;
        end
    end

    always_comb begin
        popCnt = '0;
        for (int i = 0; i < LANES; i++) begin
            popCnt = popCnt + SUM_W'(outZ_q[i]);
        end
        sum   = SUM_W'(cnt_q) + popCnt;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (outConsume) begin
            if (sum > SUM_W'(CNT_MAX)) begin
                cnt_d = CNT_MAX;
                ovf_d = 1'b1;
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1Valid_q <= 1'b0;
            s1Mode_q  <= MODE_NET;
            s1X_q     <= '0;
            s1Y_q     <= '0;
            s2Valid_q <= 1'b0;
            outZ_q    <= '0;
            fb_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Mode_q  <= s1Mode_d;
            s1X_q     <= s1X_d;
            s1Y_q     <= s1Y_d;
            s2Valid_q <= s2Valid_d;
            outZ_q    <= outZ_d;
            fb_q      <= fb_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid_o = s2Valid_q;
    assign out_z_o     = outZ_q;
    assign ones_cnt_o  = cnt_q;
    assign ovf_o       = ovf_q;

endmodule
